mem_stage: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs and performs
//  LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack data-memory port. Raises a stall request to control

---
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port used by the MEM stage.
// The MEM stage is the master; memory (or the bench) is the slave.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  byte_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, byte_en, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, byte_en, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: byte/half/word loads and stores over a req/ack port,
// stalling the front of the pipeline while an access is outstanding.
//
// state | meaning
// IDLE  | no access in flight; non-mem ops pass through, aligned mem ops issue req
// WAIT  | req held, waiting for ack; timeout counter running
// DONE  | access finished; load result / bus error presented, pipeline advances
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  mem_operator,
  input  logic [31:0] mem_operand_a,
  input  logic [31:0] mem_operand_b,
  input  logic        mem_reg_write_enable,
  input  logic [4:0]  mem_reg_write_address,
  input  logic [31:0] mem_reg_write_data,
  mem_stage_if.master dmem,
  output logic        wb_reg_write_enable,
  output logic [4:0]  wb_reg_write_address,
  output logic [31:0] wb_reg_write_data,
  output logic        stall_request,
  output logic        exc_misaligned,
  output logic        exc_bus_error
);

  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LH  = 8'h21;
  localparam logic [7:0] OP_LW  = 8'h23;
  localparam logic [7:0] OP_LBU = 8'h24;
  localparam logic [7:0] OP_LHU = 8'h25;
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_SH  = 8'h29;
  localparam logic [7:0] OP_SW  = 8'h2B;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] count, count_nxt;
  logic [31:0]          load_data, load_data_nxt;
  logic                 bus_err, bus_err_nxt;

  logic is_load, is_store, is_mem;
  logic size_byte, size_half, size_word, sign_ext;
  logic misaligned;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_result;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    size_byte = 1'b0;
    size_half = 1'b0;
    sign_ext  = 1'b0;
    case (mem_operator)
      OP_LB:   begin is_load  = 1'b1; size_byte = 1'b1; sign_ext = 1'b1; end
      OP_LBU:  begin is_load  = 1'b1; size_byte = 1'b1; end
      OP_LH:   begin is_load  = 1'b1; size_half = 1'b1; sign_ext = 1'b1; end
      OP_LHU:  begin is_load  = 1'b1; size_half = 1'b1; end
      OP_LW:   is_load = 1'b1;
      OP_SB:   begin is_store = 1'b1; size_byte = 1'b1; end
      OP_SH:   begin is_store = 1'b1; size_half = 1'b1; end
      OP_SW:   is_store = 1'b1;
      default: ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign size_word  = is_mem & ~size_byte & ~size_half;
  assign misaligned = (size_half & mem_operand_a[0]) | (size_word & (|mem_operand_a[1:0]));

  // Bus fields come straight from the held EX/MEM register, so they stay stable while req is high.
  assign dmem.we   = is_store;
  assign dmem.addr = {mem_operand_a[31:2], 2'b00};

  always_comb begin
    dmem.byte_en = 4'b1111;
    dmem.wdata   = mem_operand_b;
    if (size_byte) begin
      dmem.byte_en = 4'b0001 << mem_operand_a[1:0];
      dmem.wdata   = {4{mem_operand_b[7:0]}};
    end else if (size_half) begin
      dmem.byte_en = 4'b0011 << {mem_operand_a[1], 1'b0};
      dmem.wdata   = {2{mem_operand_b[15:0]}};
    end
  end

  always_comb begin
    case (mem_operand_a[1:0])
      2'd0:    lane_byte = load_data[7:0];
      2'd1:    lane_byte = load_data[15:8];
      2'd2:    lane_byte = load_data[23:16];
      default: lane_byte = load_data[31:24];
    endcase
    lane_half = mem_operand_a[1] ? load_data[31:16] : load_data[15:0];
    if (size_byte)
      load_result = {{24{sign_ext & lane_byte[7]}}, lane_byte};
    else if (size_half)
      load_result = {{16{sign_ext & lane_half[15]}}, lane_half};
    else
      load_result = load_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= '0;
      load_data <= '0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      load_data <= load_data_nxt;
      bus_err   <= bus_err_nxt;
    end
  end

  always_comb begin
    state_nxt            = state;
    count_nxt            = count;
    load_data_nxt        = load_data;
    bus_err_nxt          = bus_err;
    dmem.req             = 1'b0;
    stall_request        = 1'b0;
    wb_reg_write_enable  = 1'b0;
    wb_reg_write_address = mem_reg_write_address;
    wb_reg_write_data    = mem_reg_write_data;
    exc_misaligned       = 1'b0;
    exc_bus_error        = 1'b0;

    case (state)
      S_IDLE: begin
        if (!is_mem) begin
          wb_reg_write_enable = mem_reg_write_enable;
        end else if (misaligned) begin
          exc_misaligned = 1'b1;
        end else begin
          dmem.req      = 1'b1;
          stall_request = 1'b1;
          count_nxt     = count + 1'b1;
          if (dmem.ack) begin
            load_data_nxt = dmem.rdata;
            state_nxt     = S_DONE;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        dmem.req      = 1'b1;
        stall_request = 1'b1;
        count_nxt     = count + 1'b1;
        // The counter includes the issuing IDLE cycle, so req is high for exactly TIMEOUT_CYCLES.
        if (dmem.ack) begin
          load_data_nxt = dmem.rdata;
          state_nxt     = S_DONE;
        end else if (count == CNT_LAST) begin
          bus_err_nxt = 1'b1;
          state_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt     = S_IDLE;
        count_nxt     = '0;
        bus_err_nxt   = 1'b0;
        exc_bus_error = bus_err;
        if (is_load) begin
          wb_reg_write_enable = mem_reg_write_enable & ~bus_err;
          wb_reg_write_data   = bus_err ? 32'h0 : load_result;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (reset) begin
      dmem.req             = 1'b0;
      stall_request        = 1'b0;
      wb_reg_write_enable  = 1'b0;
      wb_reg_write_address = 5'd0;
      wb_reg_write_data    = 32'h0;
      exc_misaligned       = 1'b0;
      exc_bus_error        = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model predicts every cycle of each
// operation (req cycles, DONE cycle, pass-through) and one process compares on the falling edge.
module tb_mem_stage;
  localparam int TO = 4;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LH  = 8'h21;
  localparam logic [7:0] OP_LW  = 8'h23;
  localparam logic [7:0] OP_LBU = 8'h24;
  localparam logic [7:0] OP_LHU = 8'h25;
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_SH  = 8'h29;
  localparam logic [7:0] OP_SW  = 8'h2B;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  mem_operator = 8'h0;
  logic [31:0] mem_operand_a = 32'h0;
  logic [31:0] mem_operand_b = 32'h0;
  logic        mem_reg_write_enable = 1'b0;
  logic [4:0]  mem_reg_write_address = 5'd0;
  logic [31:0] mem_reg_write_data = 32'h0;
  logic        wb_reg_write_enable;
  logic [4:0]  wb_reg_write_address;
  logic [31:0] wb_reg_write_data;
  logic        stall_request;
  logic        exc_misaligned;
  logic        exc_bus_error;

  mem_stage_if dmem();

  mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .mem_operator          (mem_operator),
    .mem_operand_a         (mem_operand_a),
    .mem_operand_b         (mem_operand_b),
    .mem_reg_write_enable  (mem_reg_write_enable),
    .mem_reg_write_address (mem_reg_write_address),
    .mem_reg_write_data    (mem_reg_write_data),
    .dmem                  (dmem),
    .wb_reg_write_enable   (wb_reg_write_enable),
    .wb_reg_write_address  (wb_reg_write_address),
    .wb_reg_write_data     (wb_reg_write_data),
    .stall_request         (stall_request),
    .exc_misaligned        (exc_misaligned),
    .exc_bus_error         (exc_bus_error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic        chk = 1'b0;
  logic        exp_req, exp_stall, exp_we, exp_wb_en, exp_mis, exp_berr, exp_wb_chk;
  logic [31:0] exp_addr, exp_wdata, exp_wb_data;
  logic [3:0]  exp_be;
  logic [4:0]  exp_wb_addr;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk) begin
      cmp("dmem_req", 32'(dmem.req), 32'(exp_req));
      cmp("stall_request", 32'(stall_request), 32'(exp_stall));
      cmp("wb_en", 32'(wb_reg_write_enable), 32'(exp_wb_en));
      cmp("exc_misaligned", 32'(exc_misaligned), 32'(exp_mis));
      cmp("exc_bus_error", 32'(exc_bus_error), 32'(exp_berr));
      if (exp_req) begin
        cmp("dmem_we", 32'(dmem.we), 32'(exp_we));
        cmp("dmem_addr", dmem.addr, exp_addr);
        cmp("dmem_byte_en", 32'(dmem.byte_en), 32'(exp_be));
        if (exp_we) cmp("dmem_wdata", dmem.wdata, exp_wdata);
      end
      if (exp_wb_chk) begin
        cmp("wb_addr", 32'(wb_reg_write_address), 32'(exp_wb_addr));
        cmp("wb_data", wb_reg_write_data, exp_wb_data);
      end
    end
  end

  function automatic int m_size(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic logic m_is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] w);
    int lane = int'(a % 4);
    int v;
    if (m_size(op) == 1) begin
      v = int'((w >> (8 * lane)) & 32'hFF);
      if (op == OP_LB && v >= 128) v -= 256;
    end else if (m_size(op) == 2) begin
      lane = lane - (lane % 2);
      v = int'((w >> (8 * lane)) & 32'hFFFF);
      if (op == OP_LH && v >= 32768) v -= 65536;
    end else begin
      v = int'(w);
    end
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_be(input logic [7:0] op, input logic [31:0] a);
    int s = m_size(op);
    int lane = int'(a % 4) / s * s;
    logic [3:0] be = 4'b0000;
    for (int i = 0; i < s; i++) be[lane + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] b);
    int s = m_size(op);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[8*(i % s) +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_exp();
    exp_req = 1'b0; exp_stall = 1'b0; exp_we = 1'b0; exp_wb_en = 1'b0;
    exp_mis = 1'b0; exp_berr = 1'b0; exp_wb_chk = 1'b0;
    exp_addr = 32'h0; exp_wdata = 32'h0; exp_be = 4'h0;
    exp_wb_addr = 5'd0; exp_wb_data = 32'h0;
  endtask

  // ack_at: the req cycle (1-based) in which ack is returned; 0 or beyond TO means no ack.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic we, input logic [4:0] rd, input logic [31:0] xd,
                        input int ack_at, input logic [31:0] rdv,
                        input logic pin, input logic [3:0] pbe, input logic [31:0] pwd,
                        input logic [31:0] pwb);
    int s = m_size(op);
    int nreq;
    logic err, ld;
    mem_operator = op; mem_operand_a = a; mem_operand_b = b;
    mem_reg_write_enable = we; mem_reg_write_address = rd; mem_reg_write_data = xd;
    dmem.ack = 1'b0; dmem.rdata = $urandom;
    clear_exp();
    exp_wb_addr = rd;
    if (s == 0) begin
      exp_wb_en = we; exp_wb_chk = we; exp_wb_data = xd;
      step();
      return;
    end
    if ((a % s) != 0) begin
      exp_mis = 1'b1;
      step();
      return;
    end
    ld   = m_is_load(op);
    err  = !(ack_at >= 1 && ack_at <= TO);
    nreq = err ? TO : ack_at;
    exp_req = 1'b1; exp_stall = 1'b1; exp_we = !ld;
    exp_addr  = a - (a % 4);
    exp_be    = pin ? pbe : m_be(op, a);
    exp_wdata = pin ? pwd : m_wdata(op, b);
    for (int k = 1; k <= nreq; k++) begin
      dmem.ack   = (k == ack_at);
      dmem.rdata = (k == ack_at) ? rdv : $urandom;
      step();
    end
    // DONE cycle; a stray ack here must be ignored
    exp_req = 1'b0; exp_stall = 1'b0;
    dmem.ack = 1'($urandom_range(0, 1)); dmem.rdata = $urandom;
    exp_berr    = err;
    exp_wb_en   = ld & we & !err;
    exp_wb_chk  = exp_wb_en;
    exp_wb_data = pin ? pwb : m_load(op, a, rdv);
    step();
    dmem.ack = 1'b0;
  endtask

  logic [7:0] ops [10];

  initial begin
    ops = '{OP_ADD, 8'h00, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    dmem.ack = 1'b0; dmem.rdata = 32'h0;
    reset = 1'b1;
    mem_operator = OP_LW; mem_operand_a = 32'h100; mem_reg_write_enable = 1'b1;
    mem_reg_write_address = 5'd7; mem_reg_write_data = 32'hDEAD_BEEF;
    clear_exp();
    exp_wb_chk = 1'b1;
    step();
    chk = 1'b1;
    step();
    reset = 1'b0;

    cmp("model_lb",  m_load(OP_LB,  32'h103, 32'h80FF_0000), 32'hFFFF_FF80);
    cmp("model_lhu", m_load(OP_LHU, 32'h102, 32'h9876_5432), 32'h0000_9876);
    cmp("model_sh_be", 32'(m_be(OP_SH, 32'h102)), 32'h0000_000C);

    run_op(OP_ADD, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234, 0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_op(OP_LB, 32'h103, 32'h0, 1'b1, 5'd9, 32'h0, 1, 32'h80FF_0000,
           1'b1, 4'b1000, 32'h0, 32'hFFFF_FF80);
    run_op(OP_SH, 32'h102, 32'h0000_ABCD, 1'b1, 5'd3, 32'h0, 4, 32'h0,
           1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0);
    run_op(OP_LW, 32'h101, 32'h0, 1'b1, 5'd4, 32'h0, 1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_op(OP_LW, 32'h200, 32'h0, 1'b1, 5'd6, 32'h0, 0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_op(OP_LHU, 32'h302, 32'h0, 1'b1, 5'd8, 32'h0, 2, 32'h9876_5432,
           1'b1, 4'b1100, 32'h0, 32'h0000_9876);

    // Reset while an access is in WAIT, then a late ack
    mem_operator = OP_LW; mem_operand_a = 32'h400; mem_reg_write_enable = 1'b1;
    mem_reg_write_address = 5'd10; dmem.ack = 1'b0;
    clear_exp();
    exp_req = 1'b1; exp_stall = 1'b1; exp_addr = 32'h400; exp_be = 4'hF;
    step();
    step();
    reset = 1'b1;
    clear_exp();
    exp_wb_chk = 1'b1;
    step();
    reset = 1'b0;
    mem_operator = OP_ADD; mem_reg_write_address = 5'd11; mem_reg_write_data = 32'h55AA;
    dmem.ack = 1'b1; dmem.rdata = 32'hFFFF_FFFF;
    clear_exp();
    exp_wb_en = 1'b1; exp_wb_chk = 1'b1; exp_wb_addr = 5'd11; exp_wb_data = 32'h55AA;
    step();
    dmem.ack = 1'b0;
    run_op(OP_LW, 32'h404, 32'h0, 1'b1, 5'd12, 32'h0, 1, 32'hCAFE_F00D,
           1'b0, 4'h0, 32'h0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [7:0]  op;
      logic [31:0] a;
      int s;
      op = ops[$urandom_range(0, 9)];
      a  = $urandom;
      s  = m_size(op);
      if (s > 0 && $urandom_range(0, 3) != 0) a = a - (a % s);
      run_op(op, a, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 6), $urandom, 1'b0, 4'h0, 32'h0, 32'h0);
    end

    chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
